// File: rtl/egress_trans.sv
// egress_trans: PCIe TX egress adapter.
// Converts sop/eop framed internal beats to tlast framed core beats,
// byte-swaps every dword into core order, enforces framing (drops stray
// beats, discontinues TLPs cut short by a new sop), gates packet starts
// on the core TX buffer count and keeps optional debug counters.
// Optional feature macro: EGRESS_DBG_CNT_EN (debug counters present when defined).
module egress_trans #(
  parameter int DATA_W     = 64,
  parameter int KEEP_W     = DATA_W / 8,
  parameter int TUSER_W    = 4,
  parameter int BUF_AV_MIN = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               s_axis_tx_tready,
  input  logic [DATA_W-1:0]  s_axis_tx_tdata,
  input  logic [KEEP_W-1:0]  s_axis_tx_tkeep,
  input  logic               s_axis_tx_sop,
  input  logic               s_axis_tx_eop,
  input  logic               s_axis_tx_tvalid,
  input  logic [TUSER_W-1:0] s_axis_tx_tuser,
  input  logic [5:0]         tx_buf_av,
  input  logic               m_axis_tx_tready,
  output logic [DATA_W-1:0]  m_axis_tx_tdata,
  output logic [KEEP_W-1:0]  m_axis_tx_tkeep,
  output logic               m_axis_tx_tlast,
  output logic               m_axis_tx_tvalid,
  output logic [TUSER_W-1:0] m_axis_tx_tuser,
  output logic [31:0]        tx_packet_len,
  output logic [31:0]        tx_sop_cnt,
  output logic [31:0]        tx_eop_cnt,
  output logic [31:0]        tx_err_cnt
);

  localparam int DW_N = DATA_W / 32;

  typedef enum logic {ST_IDLE = 1'b0, ST_PKT = 1'b1} state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   mem_data_q [2];
  logic [KEEP_W-1:0]   mem_keep_q [2];
  logic                mem_last_q [2];
  logic [TUSER_W-1:0]  mem_user_q [2];
  logic                wr_ptr_q;
  logic                rd_ptr_q;
  logic [1:0]          count_q;
  logic [1:0]          count_d;

  logic                accept_s;
  logic                forward_s;
  logic                disc_s;
  logic                last_s;
  logic                push_s;
  logic                pop_s;
  logic                gate_s;
  logic [DATA_W-1:0]   data_push_s;
  logic [KEEP_W-1:0]   keep_push_s;
  logic [TUSER_W-1:0]  user_push_s;

  // Reverse the byte order inside each 32-bit dword.
  function automatic logic [DATA_W-1:0] dword_swap(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DW_N; i++) begin
      r[i*32 +: 32] = {d[i*32 +: 8], d[i*32+8 +: 8], d[i*32+16 +: 8], d[i*32+24 +: 8]};
    end
    return r;
  endfunction

  // Packet starts wait for core buffers; an open packet is never stalled by the gate.
  always_comb begin
    gate_s           = (state_q == ST_IDLE) && (tx_buf_av < 6'(BUF_AV_MIN));
    s_axis_tx_tready = rst_n && (count_q < 2'd2) && !gate_s;
    accept_s         = s_axis_tx_tvalid && s_axis_tx_tready;
    pop_s            = m_axis_tx_tvalid && m_axis_tx_tready;
  end

  // Framing decode: decide whether the accepted beat is forwarded, ends a TLP or discontinues one.
  always_comb begin
    forward_s = 1'b0;
    disc_s    = 1'b0;
    last_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        forward_s = s_axis_tx_sop;
        last_s    = s_axis_tx_eop;
      end
      ST_PKT: begin
        forward_s = 1'b1;
        if (s_axis_tx_sop) begin
          disc_s = 1'b1;
          last_s = 1'b1;
        end else begin
          last_s = s_axis_tx_eop;
        end
      end
      default: begin
        forward_s = 1'b0;
      end
    endcase
    push_s      = accept_s && forward_s;
    data_push_s = dword_swap(s_axis_tx_tdata);
    keep_push_s = disc_s ? {KEEP_W{1'b1}} : s_axis_tx_tkeep;
    user_push_s = s_axis_tx_tuser;
    if (disc_s) begin
      user_push_s[3] = 1'b1;
    end else begin
      user_push_s = s_axis_tx_tuser;
    end
  end

  // FIFO occupancy next state.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Two-entry FIFO storage and pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_data_q[i] <= '0;
        mem_keep_q[i] <= '0;
        mem_last_q[i] <= 1'b0;
        mem_user_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_s) begin
        mem_data_q[wr_ptr_q] <= data_push_s;
        mem_keep_q[wr_ptr_q] <= keep_push_s;
        mem_last_q[wr_ptr_q] <= last_s;
        mem_user_q[wr_ptr_q] <= user_push_s;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  // Framing FSM, advanced only by accepted input beats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else if (accept_s) begin
      case (state_q)
        ST_IDLE: if (s_axis_tx_sop && !s_axis_tx_eop) state_q <= ST_PKT;
        ST_PKT:  if (s_axis_tx_sop || s_axis_tx_eop) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_axis_tx_tvalid = (count_q != 2'd0);
  assign m_axis_tx_tdata  = mem_data_q[rd_ptr_q];
  assign m_axis_tx_tkeep  = mem_keep_q[rd_ptr_q];
  assign m_axis_tx_tlast  = mem_last_q[rd_ptr_q];
  assign m_axis_tx_tuser  = mem_user_q[rd_ptr_q];

`ifdef EGRESS_DBG_CNT_EN
  logic        first_q;
  logic [31:0] beats_q;
  logic [31:0] len_q;
  logic [31:0] sop_q;
  logic [31:0] eop_q;
  logic [31:0] err_q;

  // Core-side packet statistics counted on pops; framing errors counted on accepts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first_q <= 1'b1;
      beats_q <= 32'd0;
      len_q   <= 32'd0;
      sop_q   <= 32'd0;
      eop_q   <= 32'd0;
      err_q   <= 32'd0;
    end else begin
      if (pop_s) begin
        if (first_q) sop_q <= sop_q + 32'd1;
        if (m_axis_tx_tlast) begin
          len_q   <= beats_q + 32'd1;
          beats_q <= 32'd0;
          eop_q   <= eop_q + 32'd1;
          first_q <= 1'b1;
        end else begin
          beats_q <= beats_q + 32'd1;
          first_q <= 1'b0;
        end
      end
      if (accept_s && (!forward_s || disc_s)) begin
        err_q <= err_q + 32'd1;
      end
    end
  end

  assign tx_packet_len = len_q;
  assign tx_sop_cnt    = sop_q;
  assign tx_eop_cnt    = eop_q;
  assign tx_err_cnt    = err_q;
`else
  assign tx_packet_len = 32'd0;
  assign tx_sop_cnt    = 32'd0;
  assign tx_eop_cnt    = 32'd0;
  assign tx_err_cnt    = 32'd0;
`endif

endmodule
